// File: rtl/dpram_rd_frontend_if.sv
// Read-side bus bundle for dpram_rd_frontend: request channel, RAM read port and response channel.
// slave is the front end's view; master is the view of the request/RAM/consumer side.
interface dpram_rd_frontend_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64
);
  logic                  REQ_VALID;
  logic [ADDR_WIDTH-1:0] REQ_ADDR;
  logic                  REQ_READY;
  logic                  ARVALID;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic                  RVALID;
  logic [DATA_WIDTH-1:0] RDATA;
  logic                  RESP_VALID;
  logic [DATA_WIDTH-1:0] RESP_DATA;
  logic                  RESP_READY;

  modport slave (
    input  REQ_VALID, REQ_ADDR, RVALID, RDATA, RESP_READY,
    output REQ_READY, ARVALID, ARADDR, RESP_VALID, RESP_DATA
  );

  modport master (
    output REQ_VALID, REQ_ADDR, RVALID, RDATA, RESP_READY,
    input  REQ_READY, ARVALID, ARADDR, RESP_VALID, RESP_DATA
  );
endinterface

// File: rtl/dpram_rd_frontend.sv
// Credit-controlled read front end for the dual-port RAM: issues reads, buffers 1-cycle responses in a FIFO.
// Define DPRAM_RD_BYPASS_EN to forward a capture straight to the consumer when the FIFO is empty.
module dpram_rd_frontend #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4
) (
  input  logic                         CLK,
  input  logic                         RESET,
  dpram_rd_frontend_if.slave           bus,
  output logic [$clog2(DEPTH+1)-1:0]   OUTSTANDING,
  output logic                         ERR_SPURIOUS
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [CW-1:0]         outstanding_q;
  logic [CW-1:0]         occ_q;
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic                  issued_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  req_ready;
  logic                  accept;
  logic                  capture;
  logic                  fifo_empty;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  consume;
  logic                  push;
  logic                  fifo_pop;

  // Stage p0: request acceptance and issue to the RAM
  always_comb begin
    req_ready  = (outstanding_q < CW'(DEPTH)) & ~RESET;
    accept     = bus.REQ_VALID & req_ready;
    capture    = bus.RVALID & issued_q;
    fifo_empty = (occ_q == '0);
    resp_valid = 1'b0;
    resp_data  = mem_q[rd_ptr_q];
    consume    = 1'b0;
    push       = 1'b0;
    fifo_pop   = 1'b0;
`ifdef DPRAM_RD_BYPASS_EN
    // An empty FIFO lets the capture reach the consumer in the same cycle.
    resp_valid = (~fifo_empty | capture) & ~RESET;
    resp_data  = fifo_empty ? bus.RDATA : mem_q[rd_ptr_q];
    consume    = resp_valid & bus.RESP_READY;
    push       = capture & ~(fifo_empty & bus.RESP_READY);
    fifo_pop   = consume & ~fifo_empty;
`else
    resp_valid = ~fifo_empty & ~RESET;
    consume    = resp_valid & bus.RESP_READY;
    push       = capture;
    fifo_pop   = consume;
`endif
  end

  assign bus.REQ_READY  = req_ready;
  assign bus.ARVALID    = accept;
  assign bus.ARADDR     = bus.REQ_ADDR;
  assign bus.RESP_VALID = resp_valid;
  assign bus.RESP_DATA  = resp_data;
  assign OUTSTANDING    = outstanding_q;
  assign ERR_SPURIOUS   = err_q;

  // Stage p1: response capture, credit and pointer bookkeeping
  always_ff @(posedge CLK) begin
    if (RESET) begin
      outstanding_q <= '0;
      occ_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      issued_q      <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      issued_q <= accept;
      if (bus.RVALID & ~issued_q)
        err_q <= 1'b1;
      case ({accept, consume})
        2'b10:   outstanding_q <= outstanding_q + CW'(1);
        2'b01:   outstanding_q <= outstanding_q - CW'(1);
        default: outstanding_q <= outstanding_q;
      endcase
      case ({push, fifo_pop})
        2'b10:   occ_q <= occ_q + CW'(1);
        2'b01:   occ_q <= occ_q - CW'(1);
        default: occ_q <= occ_q;
      endcase
      // DEPTH is a power of two, so the pointers wrap by natural overflow.
      if (push)
        wr_ptr_q <= wr_ptr_q + PW'(1);
      if (fifo_pop)
        rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Storage carries data only and is not reset.
  always_ff @(posedge CLK) begin
    if (push)
      mem_q[wr_ptr_q] <= bus.RDATA;
  end
endmodule

// File: tb/tb_dpram_rd_frontend.sv
// Directed bench for dpram_rd_frontend (DEPTH=4) with a 1-cycle RAM model returning ADDR+0x100.
module tb_dpram_rd_frontend;
  localparam int AW = 10;
  localparam int DW = 64;
  localparam int DP = 4;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [2:0]    OUTSTANDING;
  logic          ERR_SPURIOUS;
  logic          spur;
  logic          rv_q = 1'b0;
  logic [DW-1:0] rd_q = '0;
  logic [2:0]    max_out = '0;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [63:0]   got[$];
  logic [63:0]   exp[$];

  dpram_rd_frontend_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  dpram_rd_frontend #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .bus          (bus),
    .OUTSTANDING  (OUTSTANDING),
    .ERR_SPURIOUS (ERR_SPURIOUS)
  );

  always #5 CLK = ~CLK;

  // RAM model: fixed 1-cycle read latency; spur injects an unrequested response.
  always_ff @(posedge CLK) begin
    rv_q <= bus.ARVALID;
    rd_q <= 64'(bus.ARADDR) + 64'h100;
  end
  assign bus.RVALID = rv_q | spur;
  assign bus.RDATA  = spur ? 64'hDEAD_BEEF : rd_q;

  always @(negedge CLK) begin
    if (!RESET && bus.RESP_VALID && bus.RESP_READY) got.push_back(bus.RESP_DATA);
    if (OUTSTANDING > max_out) max_out = OUTSTANDING;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
    n_checks++;
    if (obs !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, req);
    end
  endtask

  task automatic next_cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  task automatic drain(input int n);
    int k;
    bus.REQ_VALID  = 1'b0;
    bus.RESP_READY = 1'b1;
    k = 0;
    while (got.size() < n && k < 200) begin
      next_cyc();
      k++;
    end
    check("drain_count", 64'(got.size()), 64'(n));
    for (int i = 0; i < n && i < got.size() && i < exp.size(); i++)
      check("resp_order", got[i], exp[i]);
    mid();
    check("drain_resp_valid", 64'(bus.RESP_VALID), 64'd0);
    check("drain_outstanding", 64'(OUTSTANDING), 64'd0);
    next_cyc();
    got.delete();
    exp.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int sent;
    int k;
    RESET          = 1'b1;
    spur           = 1'b0;
    bus.REQ_VALID  = 1'b1;
    bus.REQ_ADDR   = '0;
    bus.RESP_READY = 1'b1;
    next_cyc();
    next_cyc();
    // Reset state with a request pending
    mid();
    check("rst_req_ready", 64'(bus.REQ_READY), 64'd0);
    check("rst_arvalid", 64'(bus.ARVALID), 64'd0);
    check("rst_resp_valid", 64'(bus.RESP_VALID), 64'd0);
    check("rst_outstanding", 64'(OUTSTANDING), 64'd0);
    check("rst_err", 64'(ERR_SPURIOUS), 64'd0);
    next_cyc();
    RESET         = 1'b0;
    bus.REQ_VALID = 1'b0;
    mid();
    check("idle_req_ready", 64'(bus.REQ_READY), 64'd1);
    next_cyc();

    // Single request latency
    bus.REQ_VALID = 1'b1;
    bus.REQ_ADDR  = 10'h005;
    mid();
    check("single_arvalid", 64'(bus.ARVALID), 64'd1);
    check("single_araddr", 64'(bus.ARADDR), 64'h005);
    next_cyc();
    bus.REQ_VALID = 1'b0;
    mid();
    check("single_outstanding_n1", 64'(OUTSTANDING), 64'd1);
`ifdef DPRAM_RD_BYPASS_EN
    check("single_valid_n1", 64'(bus.RESP_VALID), 64'd1);
    check("single_data_n1", bus.RESP_DATA, 64'h105);
    next_cyc();
    mid();
    check("single_valid_n2", 64'(bus.RESP_VALID), 64'd0);
`else
    check("single_valid_n1", 64'(bus.RESP_VALID), 64'd0);
    next_cyc();
    mid();
    check("single_valid_n2", 64'(bus.RESP_VALID), 64'd1);
    check("single_data_n2", bus.RESP_DATA, 64'h105);
`endif
    next_cyc();
    mid();
    check("single_outstanding_end", 64'(OUTSTANDING), 64'd0);
    check("single_valid_end", 64'(bus.RESP_VALID), 64'd0);
    next_cyc();
    got.delete();

    // Fill to DEPTH with consumer stalled, then one pop frees one credit
    bus.RESP_READY = 1'b0;
    bus.REQ_VALID  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.REQ_ADDR = AW'(i);
      mid();
      check("fill_req_ready", 64'(bus.REQ_READY), 64'd1);
      exp.push_back(64'h100 + 64'(i));
      next_cyc();
    end
    bus.REQ_ADDR = 10'h004;
    mid();
    check("full_req_ready", 64'(bus.REQ_READY), 64'd0);
    check("full_arvalid", 64'(bus.ARVALID), 64'd0);
    check("full_outstanding", 64'(OUTSTANDING), 64'd4);
    check("full_head_data", bus.RESP_DATA, 64'h100);
    next_cyc();
    bus.RESP_READY = 1'b1;
    mid();
    check("pop_cycle_req_ready", 64'(bus.REQ_READY), 64'd0);
    next_cyc();
    bus.RESP_READY = 1'b0;
    mid();
    check("refill_req_ready", 64'(bus.REQ_READY), 64'd1);
    check("refill_araddr", 64'(bus.ARADDR), 64'h004);
    exp.push_back(64'h104);
    next_cyc();
    bus.REQ_VALID = 1'b0;
    mid();
    check("refill_outstanding", 64'(OUTSTANDING), 64'd4);
    check("refill_head_data", bus.RESP_DATA, 64'h101);
    next_cyc();
    drain(5);

    // Streaming 16 requests at full rate
    bus.RESP_READY = 1'b1;
    bus.REQ_VALID  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.REQ_ADDR = AW'(i);
      mid();
      check("stream_no_stall", 64'(bus.REQ_READY), 64'd1);
      exp.push_back(64'h100 + 64'(i));
      next_cyc();
    end
    drain(16);

    // Consumer ready toggling every cycle
    sent = 0;
    k    = 0;
    while (sent < 12 && k < 200) begin
      bus.REQ_VALID  = 1'b1;
      bus.REQ_ADDR   = AW'(10'h020 + sent);
      bus.RESP_READY = k[0];
      mid();
      if (bus.REQ_READY) begin
        exp.push_back(64'h120 + 64'(sent));
        sent++;
      end
      next_cyc();
      k++;
    end
    check("toggle_sent", 64'(sent), 64'd12);
    drain(12);
    check("toggle_max_outstanding_le_depth", 64'(max_out <= 3'd4), 64'd1);

    // Spurious RVALID with nothing in flight
    spur = 1'b1;
    mid();
    check("spur_resp_valid", 64'(bus.RESP_VALID), 64'd0);
    next_cyc();
    spur = 1'b0;
    mid();
    check("spur_err", 64'(ERR_SPURIOUS), 64'd1);
    check("spur_resp_valid_after", 64'(bus.RESP_VALID), 64'd0);
    check("spur_outstanding", 64'(OUTSTANDING), 64'd0);
    next_cyc();
    next_cyc();
    next_cyc();
    mid();
    check("spur_err_sticky", 64'(ERR_SPURIOUS), 64'd1);
    next_cyc();

    // Reset with 3 buffered and 1 in flight, then trailing RVALID after release
    bus.RESP_READY = 1'b0;
    bus.REQ_VALID  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.REQ_ADDR = AW'(10'h030 + i);
      next_cyc();
    end
    bus.REQ_VALID = 1'b0;
    RESET         = 1'b1;
    mid();
    check("midrst_resp_valid", 64'(bus.RESP_VALID), 64'd0);
    check("midrst_req_ready", 64'(bus.REQ_READY), 64'd0);
    next_cyc();
    RESET = 1'b0;
    spur  = 1'b1;
    mid();
    check("postrst_outstanding", 64'(OUTSTANDING), 64'd0);
    check("postrst_resp_valid", 64'(bus.RESP_VALID), 64'd0);
    check("postrst_err_cleared", 64'(ERR_SPURIOUS), 64'd0);
    next_cyc();
    spur = 1'b0;
    mid();
    check("trailing_err", 64'(ERR_SPURIOUS), 64'd1);
    check("trailing_resp_valid", 64'(bus.RESP_VALID), 64'd0);
    check("trailing_outstanding", 64'(OUTSTANDING), 64'd0);
    next_cyc();
    got.delete();
    bus.REQ_VALID  = 1'b1;
    bus.REQ_ADDR   = 10'h00A;
    bus.RESP_READY = 1'b1;
    mid();
    check("postrst_accept", 64'(bus.REQ_READY), 64'd1);
    exp.push_back(64'h10A);
    next_cyc();
    drain(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
